// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator for a single slave.
// Runs one 8-bit full-duplex frame per accepted start and returns the received
// byte with a one-cycle done pulse. SCLK and CS are derived from clk.
// Optional build macro: SPI_MASTER_MSB_FIRST_EN selects MSB-first frames
// (default build is LSB first; timing and handshakes are identical).
module spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] masterDataToSend,
    input  logic       MISO,
    output logic       SCLK,
    output logic       CS,
    output logic       MOSI,
    output logic [7:0] masterDataReceived,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Terminal value of the half-period counter.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_r,    state_s;
    logic [7:0] half_cnt_r, half_cnt_s;
    logic [3:0] bit_cnt_r,  bit_cnt_s;
    logic [7:0] tx_r,       tx_s;
    logic [7:0] rx_r,       rx_s;
    logic [7:0] rx_out_r,   rx_out_s;
    logic       sclk_r,     sclk_s;
    logic       cs_r,       cs_s;
    logic       mosi_r,     mosi_s;
    logic       busy_r,     busy_s;
    logic       done_r,     done_s;
    logic       half_last_s;

    // Map frame bit position (0 = first on the wire) to byte bit index.
    function automatic logic [2:0] lane(input logic [2:0] pos);
`ifdef SPI_MASTER_MSB_FIRST_EN
        return 3'd7 - pos;
`else
        return pos;
`endif
    endfunction

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s     = state_r;
        half_cnt_s  = half_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        tx_s        = tx_r;
        rx_s        = rx_r;
        rx_out_s    = rx_out_r;
        sclk_s      = sclk_r;
        cs_s        = cs_r;
        mosi_s      = mosi_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        half_last_s = (half_cnt_r == DIV_LAST);

        case (state_r)
            IDLE: begin
                half_cnt_s = 8'd0;
                if (start) begin
                    tx_s      = masterDataToSend;
                    cs_s      = 1'b0;
                    mosi_s    = masterDataToSend[lane(3'd0)];
                    busy_s    = 1'b1;
                    bit_cnt_s = 4'd0;
                    rx_s      = 8'h00;
                    state_s   = SETUP;
                end else begin
                    cs_s   = 1'b1;
                    sclk_s = 1'b0;
                end
            end
            SETUP: begin
                if (half_last_s) begin
                    // First rising SCLK edge: sample bit 0 from the slave.
                    half_cnt_s                  = 8'd0;
                    sclk_s                      = 1'b1;
                    rx_s[lane(bit_cnt_r[2:0])]  = MISO;
                    state_s                     = SHIFT;
                end else begin
                    half_cnt_s = half_cnt_r + 8'd1;
                end
            end
            SHIFT: begin
                if (half_last_s) begin
                    half_cnt_s = 8'd0;
                    sclk_s     = ~sclk_r;
                    if (!sclk_r) begin
                        // Rising edge: capture MISO.
                        rx_s[lane(bit_cnt_r[2:0])] = MISO;
                    end else begin
                        // Falling edge: advance to the next bit or finish.
                        bit_cnt_s = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            state_s = HOLD;
                        end else begin
                            mosi_s = tx_r[lane(bit_cnt_r[2:0] + 3'd1)];
                        end
                    end
                end else begin
                    half_cnt_s = half_cnt_r + 8'd1;
                end
            end
            HOLD: begin
                if (half_last_s) begin
                    half_cnt_s = 8'd0;
                    cs_s       = 1'b1;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    rx_out_s   = rx_r;
                    state_s    = IDLE;
                end else begin
                    half_cnt_s = half_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s    = IDLE;
                half_cnt_s = 8'd0;
                bit_cnt_s  = 4'd0;
                sclk_s     = 1'b0;
                cs_s       = 1'b1;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            half_cnt_r <= 8'd0;
            bit_cnt_r  <= 4'd0;
            tx_r       <= 8'h00;
            rx_r       <= 8'h00;
            rx_out_r   <= 8'h00;
            sclk_r     <= 1'b0;
            cs_r       <= 1'b1;
            mosi_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            half_cnt_r <= half_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            tx_r       <= tx_s;
            rx_r       <= rx_s;
            rx_out_r   <= rx_out_s;
            sclk_r     <= sclk_s;
            cs_r       <= cs_s;
            mosi_r     <= mosi_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign SCLK               = sclk_r;
    assign CS                 = cs_r;
    assign MOSI               = mosi_r;
    assign masterDataReceived = rx_out_r;
    assign busy               = busy_r;
    assign done               = done_r;

endmodule

// File: doc/spi_master.md
# spi_master

- SPI master (initiator) for the single-slave SPI link.
- Mode 0: SCLK idles low, MOSI/MISO change on SCLK falling edge, sampled on rising edge. 8-bit full-duplex frames, LSB first by default.
- Sits between the host-side register logic and the SPI slave, generating SCLK and CS from the system clock.
- Each accepted `start` runs exactly one frame and returns the received byte with a one-cycle `done` pulse.

## Interface
Parameters:
- CLK_DIV, default 2: `clk` cycles per SCLK half-period. Legal range 1..255; the implementation does not check the range.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  frame request. Sampled only while `busy`=0.
- masterDataToSend  in  8  byte to transmit; captured on the edge that accepts `start`.
- MISO  in  1  serial data from the slave.
- SCLK  out  1  serial clock.
- CS  out  1  chip select, active low.
- MOSI  out  1  serial data to the slave.
- masterDataReceived  out  8  last complete received byte.
- busy  out  1  high from frame acceptance until `done`.
- done  out  1  one-cycle pulse when the frame completes.

## Operation
- Reset values (applied asynchronously while `reset`=0):
  - CS=1, SCLK=0, MOSI=0, busy=0, done=0
  - masterDataReceived=8'h00
  - state IDLE, half-period counter 0, bit counter 0
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - done=0 except on the single return cycle described under HOLD.
  - With start=1: load tx shift register from masterDataToSend, CS←0, MOSI←bit 0, busy←1, bit counter←0, go to SETUP.
- SETUP: hold CS low, SCLK low for CLK_DIV cycles, then SCLK←1 and go to SHIFT.
- SHIFT: SCLK toggles every CLK_DIV cycles.
  - Rising edge (SCLK 0→1): sample MISO into the rx shift register.
  - Falling edge (SCLK 1→0): bit counter +1. If counter < 8, MOSI←next tx bit. On the 8th falling edge, go to HOLD; MOSI holds its last value.
- HOLD: SCLK low, CS low for CLK_DIV cycles. Then, all on the same edge:
  - CS←1, busy←0, done←1
  - masterDataReceived←rx shift register
  - go to IDLE
- Bit order:
  - LSB first: bit i of masterDataToSend is driven during SCLK period i.
  - The MISO bit sampled on rising edge i lands in bit i of masterDataReceived.
- `start` while busy=1 is ignored; it is not queued.
- masterDataToSend changes after acceptance have no effect on the frame in progress.
- Back-to-back frames:
  - `start` is accepted on the cycle done=1, since busy=0 on that cycle.
  - CS then rises for exactly one clk cycle before falling again.
- masterDataReceived holds its value between frames and is never partially updated.
- Reset asserted mid-frame: all outputs return to reset values immediately; the partial frame is discarded. After reset release, nothing happens until a new `start`.

## Timing
- Let E0 be the clk edge that accepts `start`.
- SCLK transitions at E0 + k·CLK_DIV, for k = 1..16. Odd k is rising, even k is falling.
- HOLD is entered at E0 + 16·CLK_DIV.
- CS rises, done=1 and masterDataReceived is valid at E0 + 17·CLK_DIV. With CLK_DIV=2 this is 34 cycles.
- CS low for exactly 17·CLK_DIV clk cycles per frame.
- MOSI setup before each rising SCLK edge: CLK_DIV cycles. MOSI is stable for a full SCLK period.
- done is high for exactly one clk cycle per frame.

## Configuration
- Macro `SPI_MASTER_MSB_FIRST_EN`.
- Defined:
  - Frames are MSB first: bit 7 is driven in SCLK period 0.
  - The MISO bit sampled on rising edge i lands in bit 7−i.
  - Timing and handshakes are unchanged.
- Undefined: LSB first, as specified above.

## Test plan
- Reset check: reset=0 held 5 cycles, then released. Required: CS=1, SCLK=0, MOSI=0, busy=0, done=0, masterDataReceived=8'h00, with no SCLK activity.
- Single frame, CLK_DIV=2, masterDataToSend=8'hA5, slave model returns 8'h3C LSB first.
  - MOSI sequence 1,0,1,0,0,1,0,1 across 8 SCLK periods.
  - done at E0+34; masterDataReceived=8'h3C; CS low for 34 cycles.
- Busy rejection: send 8'h0F, then pulse start with data 8'hFF at E0+10.
  - The 8'hFF request is ignored; exactly one frame occurs; MOSI carries 8'h0F.
- Back-to-back: start held high continuously with data 8'h01 then 8'h80.
  - Two frames with CS high exactly 1 cycle between them.
  - Two done pulses, 35 cycles apart.
- Reset mid-frame: assert reset at E0+15.
  - Outputs are at reset values within the same cycle; no done pulse.
  - masterDataReceived=8'h00.
  - A subsequent frame sending 8'h5A completes correctly.
- MSB-first build (SPI_MASTER_MSB_FIRST_EN defined), CLK_DIV=1, send 8'hC1, slave returns 8'h81 MSB first.
  - MOSI sequence 1,1,0,0,0,0,0,1.
  - masterDataReceived=8'h81 at E0+17.
